q_agent_engine: RTL

Q_AGENT_ENGINE -- requirements
Module: q_agent_engine

---
 rtl/q_agent_pkg.sv | 32 +++
 rtl/q_update_alu.sv | 36 +++
 rtl/q_agent_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/q_agent_pkg.sv
// Shared types and helpers for the Q-learning agent: FSM states, LFSR constants
// and a signed saturation helper.
package q_agent_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      SELECT,
      ISSUE,
      WAIT_R,
      FETCH_NX,
      UPDATE,
      WRITE,
      FIN
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as a mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                     input int width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/q_update_alu.sv
// Combinational temporal-difference update: Q_old moved toward r + gamma*maxQ_next,
// computed two bits wider than Q_W and saturated back to Q_W.
module q_update_alu
   import q_agent_pkg::*;
#(
   parameter int Q_W         = 16,
   parameter int REWARD_W    = 8,
   parameter int ALPHA_SHIFT = 3,
   parameter int GAMMA_SHIFT = 1
) (
   input  logic signed [Q_W-1:0]      q_old,
   input  logic signed [REWARD_W-1:0] reward,
   input  logic signed [Q_W-1:0]      maxq_next,
   output logic signed [Q_W-1:0]      q_new
);

   localparam int W = Q_W + 2;

   logic signed [W-1:0] q_ext;
   logic signed [W-1:0] r_ext;
   logic signed [W-1:0] m_ext;
   logic signed [W-1:0] target;
   logic signed [W-1:0] delta;
   logic signed [W-1:0] sum;

   always_comb begin
      q_ext  = W'(q_old);
      r_ext  = W'(reward);
      m_ext  = W'(maxq_next);
      target = r_ext + (m_ext >>> GAMMA_SHIFT);
      delta  = (target - q_ext) >>> ALPHA_SHIFT;
      sum    = q_ext + delta;
      q_new  = Q_W'(sat_signed(32'(sum), Q_W));
   end

endmodule

// File: rtl/q_agent_engine.sv
// Q-learning agent step engine: fetch a Q-row, pick the best legal action, optionally
// learn from the reward. Define Q_AGENT_EXPLORE_EN for LFSR epsilon-greedy exploration.
module q_agent_engine
   import q_agent_pkg::*;
#(
   parameter int N_ACTIONS   = 9,
   parameter int Q_W         = 16,
   parameter int STATE_W     = 18,
   parameter int REWARD_W    = 8,
   parameter int ALPHA_SHIFT = 3,
   parameter int GAMMA_SHIFT = 1
`ifdef Q_AGENT_EXPLORE_EN
   ,
   parameter logic [7:0] EPSILON = 8'd26
`endif
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       training,
   input  logic [N_ACTIONS-1:0]       legal_mask,
   input  logic [N_ACTIONS*Q_W-1:0]   q_in,
   input  logic                       q_valid,
   input  logic signed [REWARD_W-1:0] reward,
   input  logic                       reward_valid,
   output logic [3:0]                 action_out,
   output logic                       action_valid,
   output logic [N_ACTIONS-1:0]       q_wr_en,
   output logic signed [Q_W-1:0]      q_wr_data,
   output logic                       busy,
   output logic                       done,
   output logic                       no_move,
   output logic [15:0]                step_count
);

   localparam int         IDX_W    = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;
   localparam logic [3:0] LAST_IDX = 4'(N_ACTIONS - 1);

   state_t state, state_nx;

   logic signed [Q_W-1:0]      q_row [N_ACTIONS];
   logic [N_ACTIONS-1:0]       mask_r;
   logic [3:0]                 scan_idx;
   logic [3:0]                 best_idx;
   logic signed [Q_W-1:0]      best_val;
   logic                       found;
   logic                       training_r;
   logic                       no_move_r;
   logic signed [REWARD_W-1:0] reward_r;
   logic signed [Q_W-1:0]      maxq_next;
   logic signed [Q_W-1:0]      maxq_next_r;
   logic signed [Q_W-1:0]      q_old;
   logic signed [Q_W-1:0]      q_new;

   logic signed [Q_W-1:0]      scan_q;
   logic                       scan_legal;
   logic                       take;
   logic                       scan_last;
   logic                       sel_any;
   logic [3:0]                 greedy_idx;
   logic [3:0]                 final_idx;
   logic                       explore_use;
   logic [3:0]                 explore_idx;

   always_comb begin
      scan_q     = q_row[scan_idx[IDX_W-1:0]];
      scan_legal = mask_r[scan_idx[IDX_W-1:0]];
      take       = scan_legal && (!found || (scan_q > best_val));
      scan_last  = (scan_idx == LAST_IDX);
      sel_any    = found || scan_legal;
      greedy_idx = take ? scan_idx : best_idx;
      final_idx  = explore_use ? explore_idx : greedy_idx;
      q_old      = q_row[action_out[IDX_W-1:0]];
   end

   // Next-state row maximum is taken over every entry, legal or not
   always_comb begin
      maxq_next = $signed(q_in[Q_W-1:0]);
      for (int k = 1; k < N_ACTIONS; k++) begin
         if ($signed(q_in[k*Q_W +: Q_W]) > maxq_next) maxq_next = $signed(q_in[k*Q_W +: Q_W]);
      end
   end

`ifdef Q_AGENT_EXPLORE_EN
   logic [15:0] lfsr;
   logic        explore_r;
   logic [3:0]  explore_start;
   logic        explore_hit;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         lfsr          <= LFSR_SEED;
         explore_r     <= 1'b0;
         explore_start <= 4'd0;
      end else begin
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
         if (state == FETCH && q_valid) begin
            explore_r     <= (lfsr[7:0] < EPSILON);
            explore_start <= 4'(int'(lfsr[15:8]) % N_ACTIONS);
         end
      end
   end

   // First legal action at or after the random start index, wrapping around
   always_comb begin
      int idx;
      explore_hit = 1'b0;
      explore_idx = 4'd0;
      for (int i = 0; i < N_ACTIONS; i++) begin
         idx = (int'(explore_start) + i) % N_ACTIONS;
         if (!explore_hit && mask_r[IDX_W'(idx)]) begin
            explore_hit = 1'b1;
            explore_idx = 4'(idx);
         end
      end
      explore_use = explore_r && explore_hit;
   end
`else
   assign explore_use = 1'b0;
   assign explore_idx = 4'd0;
`endif

   q_update_alu #(
      .Q_W        (Q_W),
      .REWARD_W   (REWARD_W),
      .ALPHA_SHIFT(ALPHA_SHIFT),
      .GAMMA_SHIFT(GAMMA_SHIFT)
   ) u_alu (
      .q_old    (q_old),
      .reward   (reward_r),
      .maxq_next(maxq_next_r),
      .q_new    (q_new)
   );

   always_ff @(posedge clock) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      busy         = (state != IDLE);
      done         = 1'b0;
      no_move      = 1'b0;
      action_valid = 1'b0;
      q_wr_en      = '0;
      case (state)
         IDLE:     if (start) state_nx = FETCH;
         FETCH:    if (q_valid) state_nx = SELECT;
         SELECT:   if (scan_last) state_nx = sel_any ? ISSUE : FIN;
         ISSUE: begin
            action_valid = 1'b1;
            state_nx     = training_r ? WAIT_R : FIN;
         end
         WAIT_R:   if (reward_valid) state_nx = FETCH_NX;
         FETCH_NX: if (q_valid) state_nx = UPDATE;
         UPDATE:   state_nx = WRITE;
         WRITE: begin
            q_wr_en  = N_ACTIONS'(1) << action_out;
            state_nx = FIN;
         end
         FIN: begin
            done     = 1'b1;
            no_move  = no_move_r;
            state_nx = IDLE;
         end
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (state == FETCH && q_valid) begin
         for (int k = 0; k < N_ACTIONS; k++) q_row[k] <= q_in[k*Q_W +: Q_W];
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         mask_r      <= '0;
         scan_idx    <= 4'd0;
         best_idx    <= 4'd0;
         best_val    <= '0;
         found       <= 1'b0;
         training_r  <= 1'b0;
         no_move_r   <= 1'b0;
         reward_r    <= '0;
         maxq_next_r <= '0;
         action_out  <= 4'd0;
         q_wr_data   <= '0;
         step_count  <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  training_r <= training;
                  no_move_r  <= 1'b0;
               end
            end
            FETCH: begin
               if (q_valid) begin
                  mask_r   <= legal_mask;
                  scan_idx <= 4'd0;
                  best_idx <= 4'd0;
                  best_val <= '0;
                  found    <= 1'b0;
               end
            end
            SELECT: begin
               if (take) begin
                  best_idx <= scan_idx;
                  best_val <= scan_q;
                  found    <= 1'b1;
               end
               scan_idx <= scan_idx + 4'd1;
               if (scan_last) begin
                  if (sel_any) action_out <= final_idx;
                  else         no_move_r  <= 1'b1;
               end
            end
            WAIT_R:   if (reward_valid) reward_r <= reward;
            FETCH_NX: if (q_valid) maxq_next_r <= maxq_next;
            UPDATE:   q_wr_data <= q_new;
            FIN:      step_count <= step_count + 16'd1;
            default:  ;
         endcase
      end
   end

endmodule
